// File: rtl/life_pkg.sv
// life_pkg: shared board types and the default glider seed for the life engine
package life_pkg;
    localparam int N = 8;
    typedef logic [N-1:0] row_t;
    typedef row_t [N-1:0] board_t;
    localparam logic [63:0] GLIDER_SEED = 64'h2010_7000_0000_0000;
endpackage

// File: rtl/life_if.sv
// life_if: LED row bus carrying the currently scanned board row
interface life_if;
    import life_pkg::*;
    row_t leds_out;
    modport master (output leds_out);
    modport slave (input leds_out);
endinterface

// File: rtl/life_cell.sv
// life_cell: neighbour popcount and survive/birth rule for one cell
module life_cell (
    input  logic       alive,
    input  logic [7:0] neighbours,
    output logic       next_alive
);
    logic [3:0] cnt;
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) cnt = cnt + 4'(neighbours[i]);
        next_alive = (cnt == 4'd3) || (alive && cnt == 4'd2);
    end
endmodule

// File: rtl/life_main.sv
// life_main: 8x8 toroidal life board scanned one row per clock, one generation per frame
module life_main
    import life_pkg::*;
#(
    parameter logic [63:0] SEED = GLIDER_SEED
) (
    input logic    clk,
    input logic    rst,
    life_if.master led_bus
);
    logic [2:0] row_q, row_d;
    board_t     board_q, board_d, next_gen;
    // Row r lives at packed index N-1-r and column c at bit N-1-c, matching the seed byte order
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            localparam int RU = (r + N - 1) % N;
            localparam int RD = (r + 1) % N;
            localparam int CL = (c + N - 1) % N;
            localparam int CR = (c + 1) % N;
            life_cell u_cell (
                .alive      (board_q[N-1-r][N-1-c]),
                .neighbours ({board_q[N-1-RU][N-1-CL], board_q[N-1-RU][N-1-c], board_q[N-1-RU][N-1-CR],
                              board_q[N-1-r][N-1-CL],                          board_q[N-1-r][N-1-CR],
                              board_q[N-1-RD][N-1-CL], board_q[N-1-RD][N-1-c], board_q[N-1-RD][N-1-CR]}),
                .next_alive (next_gen[N-1-r][N-1-c])
            );
        end
    end
    always_comb begin
        row_d   = row_q + 3'd1;
        board_d = (row_q == 3'(N - 1)) ? next_gen : board_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q   <= '0;
            board_q <= SEED;
        end else begin
            row_q   <= row_d;
            board_q <= board_d;
        end
    end
    assign led_bus.leds_out = board_q[~row_q];
endmodule

// File: tb/tb_life_main.sv
// tb_life_main: directed checks of glider, wrapped blinker and empty boards scanned at negedge
module tb_life_main;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    life_if glider_bus ();
    life_if blink_bus ();
    life_if zero_bus ();
    life_main u_glider (.clk(clk), .rst(rst), .led_bus(glider_bus));
    life_main #(.SEED(64'h0000_0001_0101_0000)) u_blink (.clk(clk), .rst(rst), .led_bus(blink_bus));
    life_main #(.SEED(64'h0)) u_zero (.clk(clk), .rst(rst), .led_bus(zero_bus));
    always #5 clk = ~clk;
    logic [7:0] g0 [8] = '{8'h20, 8'h10, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] g1 [8] = '{8'h00, 8'h50, 8'h30, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] g4 [8] = '{8'h00, 8'h10, 8'h08, 8'h38, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] b0 [8] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    logic [7:0] b1 [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h83, 8'h00, 8'h00, 8'h00};
    task automatic chk(input string tag, input int g, input int r, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s gen %0d row %0d: got %02h expected %02h", tag, g, r, obs, exp);
        end
    endtask
    task automatic check_row(input int g, input int r);
        if (g == 0 || g == 32) chk("glider", g, r, glider_bus.leds_out, g0[r]);
        if (g == 1 || g == 33) chk("glider", g, r, glider_bus.leds_out, g1[r]);
        if (g == 4 || g == 36) chk("glider", g, r, glider_bus.leds_out, g4[r]);
        chk("blinker", g, r, blink_bus.leds_out, (g % 2 == 0) ? b0[r] : b1[r]);
        chk("zero", g, r, zero_bus.leds_out, 8'h00);
    endtask
    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_glider", 0, 0, glider_bus.leds_out, 8'h20);
        chk("reset_blinker", 0, 0, blink_bus.leds_out, 8'h00);
        rst = 1'b0;
        for (int g = 0; g < 40; g++)
            for (int r = 0; r < 8; r++) begin
                check_row(g, r);
                @(negedge clk);
            end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        chk("pre_midreset_row4", 2, 4, glider_bus.leds_out, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_glider", 0, 0, glider_bus.leds_out, 8'h20);
        chk("midreset_blinker", 0, 0, blink_bus.leds_out, 8'h00);
        rst = 1'b0;
        for (int g = 0; g < 2; g++)
            for (int r = 0; r < 8; r++) begin
                check_row(g, r);
                @(negedge clk);
            end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
